// File: rtl/clk_pkg.sv
// Constants shared by the HDMI/DVI output path (display_if and the clock divider).
package clk_pkg;

  localparam int unsigned SERIAL_DIV       = 10;  // serial bits per pixel clock
  localparam int unsigned TMDS_W           = 10;
  localparam int unsigned DIV_MODE_DEFAULT = 5;

endpackage

// File: rtl/phase_counter.sv
// Modulo-N counter with synchronous clear; exposes the next count and its wrap flag so a
// parent can register decoded outputs in the same cycle as the count itself.
module phase_counter #(
  parameter  int unsigned N = 10,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         clear_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o,
  output logic         wrap_next_o
);

  if (N < 2) begin : g_bad_n
    $error("phase_counter: N must be at least 2");
  end

  logic [W-1:0] cnt_q;
  logic         wrap;

  assign wrap = (cnt_q == W'(N - 1));

  always_comb begin
    cnt_next_o = cnt_q + W'(1);
    if (clear_i || wrap) begin
      cnt_next_o = '0;
    end
  end

  assign wrap_next_o = (cnt_next_o == W'(N - 1));

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_next_o;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pixel_clk_divider.sv
// Portable serial-to-pixel clock divider: /2 and /(2*DIV_MODE) levels, serial phase index and
// load / pixel strobes, all registered in the clk_i domain.
module pixel_clk_divider
  import clk_pkg::*;
#(
  parameter  int unsigned DIV_MODE = DIV_MODE_DEFAULT,
  localparam int unsigned TOTAL    = 2 * DIV_MODE,
  localparam int unsigned PHASE_W  = $clog2(TOTAL)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               lock_i,
  output logic               div2_o,
  output logic               pix_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic               load_o,
  output logic               pix_stb_o
);

  if (DIV_MODE < 2 || DIV_MODE > 8) begin : g_bad_div_mode
    $error("pixel_clk_divider: DIV_MODE must be in 2..8");
  end

  logic               clear;
  logic [PHASE_W-1:0] phase_next;
  logic               wrap_next;

  // Loss of PLL lock is treated exactly like reset.
  assign clear = rst_i | ~lock_i;

  phase_counter #(
    .N (TOTAL)
  ) u_phase_counter (
    .clk_i       (clk_i),
    .clear_i     (clear),
    .cnt_o       (phase_o),
    .cnt_next_o  (phase_next),
    .wrap_next_o (wrap_next)
  );

  // Decode from the next phase so every output lines up with phase_o without a lag cycle.
  always_ff @(posedge clk_i) begin
    if (clear) begin
      div2_o    <= 1'b0;
      pix_o     <= 1'b0;
      load_o    <= 1'b0;
      pix_stb_o <= 1'b0;
    end else begin
      div2_o    <= phase_next[0];
      pix_o     <= (phase_next >= PHASE_W'(DIV_MODE));
      load_o    <= wrap_next;
      pix_stb_o <= (phase_next == PHASE_W'(DIV_MODE));
    end
  end

endmodule

// File: tb/tb_pixel_clk_divider.sv
// Directed bench for pixel_clk_divider: DIV_MODE 5, 2 and 8 instances share stimulus and are
// checked against a scoreboard of expected outputs every cycle.
module tb_pixel_clk_divider;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic lock_i = 1'b1;

  always #5 clk = ~clk;

  logic       d2_5, pix_5, ld_5, stb_5;
  logic [3:0] ph_5;
  logic       d2_2, pix_2, ld_2, stb_2;
  logic [1:0] ph_2;
  logic       d2_8, pix_8, ld_8, stb_8;
  logic [3:0] ph_8;

  pixel_clk_divider #(.DIV_MODE(5)) u_dut5 (
    .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .div2_o(d2_5), .pix_o(pix_5),
    .phase_o(ph_5), .load_o(ld_5), .pix_stb_o(stb_5)
  );
  pixel_clk_divider #(.DIV_MODE(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .div2_o(d2_2), .pix_o(pix_2),
    .phase_o(ph_2), .load_o(ld_2), .pix_stb_o(stb_2)
  );
  pixel_clk_divider #(.DIV_MODE(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst_i), .lock_i(lock_i), .div2_o(d2_8), .pix_o(pix_8),
    .phase_o(ph_8), .load_o(ld_8), .pix_stb_o(stb_8)
  );

  typedef struct {
    int   dut;
    logic [35:0] val;  // {phase(32), div2, pix, load, stb}
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   dm[3]    = '{5, 2, 8};
  int   mph[3]   = '{0, 0, 0};

  // Free-run statistics for the DIV_MODE=5 instance.
  bit   stats_on = 1'b0;
  int   n_load = 0, n_stb = 0, n_pix_rise = 0, n_d2_toggle = 0, n_pix_high = 0;
  logic prev_pix = 1'b0, prev_d2 = 1'b0;

  function automatic logic [35:0] pack(int ph, int m);
    logic d2, px, ld, sb;
    d2 = ph[0];
    px = (ph >= m);
    ld = (ph == 2 * m - 1);
    sb = (ph == m);
    return {32'(ph), d2, px, ld, sb};
  endfunction

  function automatic logic [35:0] observe(int dut);
    case (dut)
      0:       return {32'(ph_5), d2_5, pix_5, ld_5, stb_5};
      1:       return {32'(ph_2), d2_2, pix_2, ld_2, stb_2};
      default: return {32'(ph_8), d2_8, pix_8, ld_8, stb_8};
    endcase
  endfunction

  task automatic check(string tag, logic [35:0] obs, logic [35:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed phase=%0d d2/pix/ld/stb=%b expected phase=%0d d2/pix/ld/stb=%b",
             tag, obs[35:4], obs[3:0], exp[35:4], exp[3:0]);
    end
  endtask

  task automatic check_int(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, push the model's post-edge outputs, then pop and compare.
  task automatic step(input bit r, input bit l, input string tag);
    exp_t e;
    logic [35:0] o;
    rst_i  = r;
    lock_i = l;
    for (int i = 0; i < 3; i++) begin
      if (r || !l) mph[i] = 0;
      else mph[i] = (mph[i] == 2 * dm[i] - 1) ? 0 : mph[i] + 1;
      q.push_back('{dut: i, val: pack(mph[i], dm[i])});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = q.pop_front();
      o = observe(e.dut);
      check($sformatf("%s/dm%0d", tag, dm[e.dut]), o, e.val);
      check_int($sformatf("%s/dm%0d load&stb", tag, dm[e.dut]), int'(o[1] & o[0]), 0);
    end
    if (stats_on) begin
      if (ld_5) n_load++;
      if (stb_5) n_stb++;
      if (pix_5) n_pix_high++;
      if (pix_5 && !prev_pix) n_pix_rise++;
      if (d2_5 !== prev_d2) n_d2_toggle++;
    end
    prev_pix = pix_5;
    prev_d2  = d2_5;
  endtask

  task automatic run_to(int target, string tag);
    int budget = 40;
    while (mph[0] != target && budget > 0) begin
      step(1'b0, 1'b1, tag);
      budget--;
    end
    check_int({tag, " reach phase"}, mph[0], target);
  endtask

  initial begin
    // 1: three reset cycles, then restart from phase 0 with first load at cycle 9
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "reset");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "restart");

    // 2: 100-cycle free run, pulse and duty statistics
    stats_on = 1'b1;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, "freerun");
    stats_on = 1'b0;
    check_int("load pulses", n_load, 10);
    check_int("stb pulses", n_stb, 10);
    check_int("pix rises", n_pix_rise, 10);
    check_int("pix high cycles", n_pix_high, 50);
    check_int("div2 toggles", n_d2_toggle, 100);

    // 3: lock loss for two cycles at phase 6, then clean restart
    run_to(6, "to_lock");
    step(1'b0, 1'b0, "lock_lo");
    step(1'b0, 1'b0, "lock_lo");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, "relock");

    // 5: reset on the edge that would have produced load_o
    run_to(8, "to_load");
    step(1'b1, 1'b1, "rst_at_load");
    step(1'b1, 1'b0, "rst_and_unlock");
    for (int i = 0; i < 34; i++) step(1'b0, 1'b1, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
